// File: rtl/pmod_ssd_scan_mux.sv
// N-digit multiplexed seven-segment scanner: frame snapshot, leading-zero
// suppression and brightness PWM, all clocked from the 20 MHz domain.
module pmod_ssd_scan_mux #(
   parameter int P_NUM_DIGITS  = 2,
   parameter int P_SLOT_CYCLES = 100000,
   parameter int P_SEL_WIDTH   = $clog2(P_NUM_DIGITS)
) (
   input  logic                      i_clk_20mhz,
   input  logic                      i_rst_20mhz,
   input  logic [4*P_NUM_DIGITS-1:0] i_values,
   input  logic [P_NUM_DIGITS-1:0]   i_blank,
   input  logic [P_NUM_DIGITS-1:0]   i_dp,
   input  logic                      i_lz_suppress,
   input  logic [3:0]                i_brightness,
   input  logic                      i_enable,
   output logic [7:0]                o_segments,
   output logic [P_NUM_DIGITS-1:0]   o_digit_en,
   output logic [P_SEL_WIDTH-1:0]    o_sel,
   output logic                      o_frame_strobe
);

   localparam int CNT_W = $clog2(P_SLOT_CYCLES);
   localparam logic [CNT_W-1:0]       SLOT_LAST = CNT_W'(P_SLOT_CYCLES - 1);
   localparam logic [P_SEL_WIDTH-1:0] IDX_LAST  = P_SEL_WIDTH'(P_NUM_DIGITS - 1);

   logic [CNT_W-1:0]          slot_q, slot_d;
   logic [P_SEL_WIDTH-1:0]    idx_q, idx_d;
   logic [3:0]                phase_q, phase_d;
   logic                      frame_start;

   logic [4*P_NUM_DIGITS-1:0] snap_val_q;
   logic [P_NUM_DIGITS-1:0]   snap_blank_q;
   logic [P_NUM_DIGITS-1:0]   snap_dp_q;
   logic                      snap_lz_q;

   logic [P_SEL_WIDTH-1:0]    idx_p0_q;
   logic                      vld_p0_q;

   logic [7:0]                seg_q, seg_d;
   logic [P_NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
   logic [P_SEL_WIDTH-1:0]    sel_q;
   logic                      strobe_q;

   logic [P_NUM_DIGITS-1:0]   lz_mask;
   logic                      zero_run;
   logic [3:0]                nib_sel;
   logic                      dp_sel;
   logic                      blank_sel;
   logic                      lit;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      case (h)
         4'h0: hex_to_seg = 7'h3F;
         4'h1: hex_to_seg = 7'h06;
         4'h2: hex_to_seg = 7'h5B;
         4'h3: hex_to_seg = 7'h4F;
         4'h4: hex_to_seg = 7'h66;
         4'h5: hex_to_seg = 7'h6D;
         4'h6: hex_to_seg = 7'h7D;
         4'h7: hex_to_seg = 7'h07;
         4'h8: hex_to_seg = 7'h7F;
         4'h9: hex_to_seg = 7'h6F;
         4'hA: hex_to_seg = 7'h77;
         4'hB: hex_to_seg = 7'h7C;
         4'hC: hex_to_seg = 7'h39;
         4'hD: hex_to_seg = 7'h5E;
         4'hE: hex_to_seg = 7'h79;
         default: hex_to_seg = 7'h71;
      endcase
   endfunction

   always_comb begin
      frame_start = (slot_q == '0) && (idx_q == '0);
      phase_d     = phase_q + 4'd1;
      slot_d      = slot_q + 1'b1;
      idx_d       = idx_q;
      if (slot_q == SLOT_LAST) begin
         slot_d = '0;
         idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
   end

   // Stage p0: scan counters and frame snapshot; idx_p0_q tags the digit the output stage renders
   always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
      if (i_rst_20mhz) begin
         slot_q       <= '0;
         idx_q        <= '0;
         phase_q      <= '0;
         snap_val_q   <= '0;
         snap_blank_q <= '0;
         snap_dp_q    <= '0;
         snap_lz_q    <= 1'b0;
         idx_p0_q     <= '0;
         vld_p0_q     <= 1'b0;
      end else begin
         slot_q   <= slot_d;
         idx_q    <= idx_d;
         phase_q  <= phase_d;
         idx_p0_q <= idx_q;
         vld_p0_q <= 1'b1;
         if (frame_start) begin
            snap_val_q   <= i_values;
            snap_blank_q <= i_blank;
            snap_dp_q    <= i_dp;
            snap_lz_q    <= i_lz_suppress;
         end
      end
   end

   always_comb begin
      lz_mask    = '0;
      zero_run   = 1'b1;
      nib_sel    = 4'h0;
      dp_sel     = 1'b0;
      blank_sel  = 1'b0;
      digit_en_d = '0;
      // Walk from the most-significant digit down; the run of zeros ends at the first nonzero nibble
      for (int k = P_NUM_DIGITS - 1; k >= 0; k--) begin
         zero_run   = zero_run & (snap_val_q[4*k +: 4] == 4'h0);
         lz_mask[k] = snap_lz_q & zero_run & (k != 0);
      end
      for (int k = 0; k < P_NUM_DIGITS; k++) begin
         if (idx_p0_q == P_SEL_WIDTH'(k)) begin
            nib_sel       = snap_val_q[4*k +: 4];
            dp_sel        = snap_dp_q[k];
            blank_sel     = snap_blank_q[k] | lz_mask[k];
            digit_en_d[k] = 1'b1;
         end
      end
      lit   = vld_p0_q & i_enable & (phase_q <= i_brightness) & ~blank_sel;
      seg_d = lit ? {dp_sel, hex_to_seg(nib_sel)} : 8'h00;
   end

   // Stage p1: registered pin drivers
   always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
      if (i_rst_20mhz) begin
         seg_q      <= 8'h00;
         digit_en_q <= '0;
         sel_q      <= '0;
         strobe_q   <= 1'b0;
      end else begin
         seg_q      <= seg_d;
         digit_en_q <= digit_en_d;
         sel_q      <= idx_p0_q;
         strobe_q   <= frame_start;
      end
   end

   assign o_segments     = seg_q;
   assign o_digit_en     = digit_en_q;
   assign o_sel          = sel_q;
   assign o_frame_strobe = strobe_q;

endmodule
